// File: rtl/ssd_scan_driver_if.sv
// Bus between a display host and the seven-segment scan driver.
// The host (master) supplies digit codes, per-digit enables and blink
// requests; the driver (slave) returns the anode select, segment pattern
// and the end-of-frame pulse.
interface ssd_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int SEL_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [SEL_W-1:0]        digit_sel;
    logic [6:0]              seg_out;
    logic                    frame_tick;

    modport master (
        output digits, digit_en, blink_en,
        input  digit_sel, seg_out, frame_tick
    );

    modport slave (
        input  digits, digit_en, blink_en,
        output digit_sel, seg_out, frame_tick
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver.
// A prescaler paces the scan through NUM_DIGITS slots; the segment pattern
// is registered so digit_sel and seg_out always change on the same edge.
// Disabled digits show a dash, blinking digits blank on alternate periods
// of BLINK_FRAMES full frames.
// Optional feature: define SSD_LEADING_ZERO_BLANK_EN to blank leading zeros.
module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             fast_clk,
    input  logic             rst_n,
    ssd_scan_driver_if.slave bus
);
    localparam int SEL_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_DIGITS - 1);
    localparam logic [PCNT_W-1:0] LAST_PCNT = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [BCNT_W-1:0] LAST_BCNT = BCNT_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex code to segment pattern (g,c,b,a,f,e,d); B..F have no glyph here.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
        case (code)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h30;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h79;
            4'h4:    return 7'h74;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h6F;
            4'h7:    return 7'h38;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h7D;
            4'hA:    return 7'h7E;
            default: return SEG_DASH;
        endcase
    endfunction

    logic [PCNT_W-1:0] pcnt_q,  pcnt_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [6:0]        seg_q,   seg_d;
    logic              tick_q,  tick_d;
    logic [BCNT_W-1:0] bcnt_q,  bcnt_d;
    logic              phase_q, phase_d;

    logic              advance;
    logic              wrap;
    logic [6:0]        pat [NUM_DIGITS];

    // Scan timing: prescaler, digit index, frame pulse and blink state.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        advance = (pcnt_q == LAST_PCNT);
        wrap    = advance && (sel_q == LAST_SEL);
        pcnt_d  = advance ? '0 : pcnt_q + 1'b1;
        sel_d   = sel_q;
        tick_d  = wrap;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (advance) begin
            sel_d = wrap ? '0 : sel_q + 1'b1;
        end
        if (wrap) begin
            if (bcnt_q == LAST_BCNT) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    // Leading-zero detection: walk down from the top digit while everything
    // above is disabled or zero; digit 0 is never suppressed.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        lz_blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (i > 0 && higher_zero && bus.digits[4*i +: 4] == 4'h0) begin
                lz_blank[i] = 1'b1;
            end
            higher_zero = higher_zero &
                          (~bus.digit_en[i] | (bus.digits[4*i +: 4] == 4'h0));
        end
    end
`endif

    // Per-digit pattern with dash > blink > (leading-zero) > decode priority.
    // The upcoming blink phase is used so a phase change lands on the same
    // edge as the frame wrap instead of one cycle later.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pat[i] = hex_to_seg(bus.digits[4*i +: 4]);
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (lz_blank[i]) begin
                pat[i] = SEG_BLANK;
            end
`endif
            if (bus.blink_en[i] && phase_d) begin
                pat[i] = SEG_BLANK;
            end
            if (!bus.digit_en[i]) begin
                pat[i] = SEG_DASH;
            end
        end
    end

    // sel_d equals sel_q except on advance, so this reloads the current
    // digit every cycle and switches to the next digit on the advance edge.
    assign seg_d = pat[sel_d];

    // State registers with synchronous active-low reset.
    always_ff @(posedge fast_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            pcnt_q  <= '0;
            sel_q   <= '0;
            seg_q   <= SEG_BLANK;
            tick_q  <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign bus.digit_sel  = sel_q;
    assign bus.seg_out    = seg_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: two instances (4 digits / div 3 /
// blink 2 and 2 digits / div 1 / blink 3) share clock and reset. Expected
// outputs come from an arithmetic model driven by the number of edges since
// the last reset edge.
module tb_ssd_scan_driver;
    localparam int A_N = 4, A_R = 3, A_BF = 2;
    localparam int B_N = 2, B_R = 1, B_BF = 3;

    logic fast_clk = 1'b0;
    logic rst_n    = 1'b0;
    always #5 fast_clk = ~fast_clk;

    ssd_scan_driver_if #(.NUM_DIGITS(A_N)) bus_a ();
    ssd_scan_driver_if #(.NUM_DIGITS(B_N)) bus_b ();

    ssd_scan_driver #(.NUM_DIGITS(A_N), .REFRESH_DIV(A_R), .BLINK_FRAMES(A_BF)) dut_a (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .bus      (bus_a)
    );

    ssd_scan_driver #(.NUM_DIGITS(B_N), .REFRESH_DIV(B_R), .BLINK_FRAMES(B_BF)) dut_b (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .bus      (bus_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int k            = 0;   // edges since the last edge that saw rst_n low

    logic [15:0] a_d;
    logic [3:0]  a_en, a_bl;
    logic [7:0]  b_d;
    logic [1:0]  b_en, b_bl;

    logic [6:0] seg_table [16] = '{7'h3F, 7'h30, 7'h5B, 7'h79, 7'h74, 7'h6D, 7'h6F, 7'h38,
                                   7'h7F, 7'h7D, 7'h7E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int n, input int idx, input logic [31:0] d,
                                           input logic [7:0] en, input logic [7:0] bl,
                                           input bit phase);
        logic [3:0] code;
        bit         above_zero;
        code       = d[4*idx +: 4];
        above_zero = 1'b1;
        for (int j = idx + 1; j < n; j++) begin
            if (en[j] && d[4*j +: 4] != 4'h0) above_zero = 1'b0;
        end
        if (!en[idx]) return 7'h40;
        if (bl[idx] && phase) return 7'h00;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (idx > 0 && code == 4'h0 && above_zero) return 7'h00;
`endif
        return seg_table[code];
    endfunction

    task automatic check_dut(input string name, input int n, input int r, input int bf,
                             input logic [31:0] d, input logic [7:0] en, input logic [7:0] bl,
                             input logic [2:0] sel_got, input logic [6:0] seg_got,
                             input logic tick_got);
        int         sel_e;
        bit         tick_e;
        bit         ph;
        logic [6:0] seg_e;
        if (k == 0) begin
            sel_e  = 0;
            tick_e = 1'b0;
            seg_e  = 7'h00;
        end else begin
            sel_e  = (k / r) % n;
            tick_e = (k % r == 0) && (sel_e == 0);
            ph     = ((k / (r * n)) / bf) % 2 == 1;
            seg_e  = ref_seg(n, sel_e, d, en, bl, ph);
        end
        check($sformatf("%s.digit_sel k=%0d", name, k), 32'(sel_got), 32'(sel_e));
        check($sformatf("%s.seg_out k=%0d", name, k), 32'(seg_got), 32'(seg_e));
        check($sformatf("%s.frame_tick k=%0d", name, k), 32'(tick_got), 32'(tick_e));
    endtask

    task automatic apply();
        bus_a.digits   = a_d;
        bus_a.digit_en = a_en;
        bus_a.blink_en = a_bl;
        bus_b.digits   = b_d;
        bus_b.digit_en = b_en;
        bus_b.blink_en = b_bl;
    endtask

    // One clock: advance the edge count, then check both instances.
    task automatic step();
        @(posedge fast_clk);
        #1;
        if (!rst_n) k = 0;
        else        k++;
        check_dut("a", A_N, A_R, A_BF, 32'(a_d), 8'(a_en), 8'(a_bl),
                  3'(bus_a.digit_sel), bus_a.seg_out, bus_a.frame_tick);
        check_dut("b", B_N, B_R, B_BF, 32'(b_d), 8'(b_en), 8'(b_bl),
                  3'(bus_b.digit_sel), bus_b.seg_out, bus_b.frame_tick);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic randomize_b();
        b_d  = 8'($urandom);
        b_en = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        b_bl = 2'($urandom);
    endtask

    initial begin
        // Reset with arbitrary inputs.
        a_d = 16'h9876; a_en = 4'hF; a_bl = 4'h0;
        b_d = 8'h21;    b_en = 2'b11; b_bl = 2'b00;
        apply();
        rst_n = 1'b0;
        run(3);

        // Plain scan of 0x4321.
        a_d = 16'h4321; a_en = 4'hF; a_bl = 4'h0;
        apply();
        rst_n = 1'b1;
        run(30);

        // Disabled digit 2 and an undecodable code on enabled digit 3.
        a_d = 16'hC321; a_en = 4'b1011;
        randomize_b();
        apply();
        run(15);

        // Blink digit 1 over several blink periods.
        a_d = 16'h4321; a_en = 4'hF; a_bl = 4'b0010;
        b_bl = 2'b01;
        apply();
        run(120);

        // Zeros around a single non-zero digit.
        a_d = 16'h0050; a_bl = 4'h0;
        b_d = 8'h05;    b_en = 2'b11; b_bl = 2'b00;
        apply();
        run(15);

        // One-cycle reset while digit 2 is being driven.
        a_d = 16'h4321; a_bl = 4'b0100;
        apply();
        for (int g = 0; g < 40 && ((k / A_R) % A_N) != 2; g++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(40);

        // Random traffic with occasional input changes and resets.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a_d  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom) & 16'h00FF;
                a_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                a_bl = 4'($urandom);
                randomize_b();
                apply();
            end
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
